// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_rr_arbiter
//  Description : Round-robin arbiter that shares one 8:1 mux, and the
//                resource behind it, among 8 requesters. The one-hot grant is
//                registered. The mux select is the binary index of the
//                current owner. An optional hold limit forces a rotation so
//                that one requester cannot starve the others.
//
//  Parameters  : MAX_HOLD - maximum number of consecutive grant cycles while
//                           another requester is waiting. 0 = unlimited: the
//                           owner keeps the grant until it drops its request.
//                CNT_W    - width of the hold counter. It must satisfy
//                           2**CNT_W > MAX_HOLD.
//
//  Ports       : clk   in   1  system clock, rising edge
//                rst_n in   1  asynchronous active-low reset
//                req   in   8  request vector; req[i] comes from requester i
//                grant out  8  registered one-hot grant; all-zero when idle
//                sel   out  3  index of the current owner (sel[2]->S2,
//                              sel[1]->S1, sel[0]->S0); holds when idle
//                valid out  1  registered, equals |grant
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_max_hold  = CNT_W'(MAX_HOLD);
  // With an unlimited hold the counter is unused, so it is parked at zero.
  localparam logic [CNT_W-1:0] c_cnt_start = (MAX_HOLD == 0) ? '0 : CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_grant;
  logic [2:0]       r_sel;
  logic             r_valid;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Rotating priority search. This function returns {found, index} for the
  // first set bit of mask. The scan order is start, start+1, ... and wraps
  // from 7 to 0. The index arithmetic is 3 bits wide, so the wrap is free.
  // --------------------------------------------------------------------------
  function automatic logic [3:0] rr_search(input logic [7:0] mask,
                                           input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < 8; k++) begin
      cand = start + 3'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  logic [7:0] w_owner_oh;
  logic [7:0] w_others;
  logic [2:0] w_after_owner;
  logic [3:0] w_idle_hit;
  logic [3:0] w_next_hit;
  logic       w_owner_req;
  logic       w_hold_expired;

  always_comb begin
    w_owner_oh    = 8'(1) << r_sel;
    w_others      = req & ~w_owner_oh;
    w_after_owner = r_sel + 3'd1;
    w_owner_req   = req[r_sel];
    // An idle search starts at the pointer that the last release left.
    w_idle_hit    = rr_search(req, r_ptr);
    // A release and a preempt share one search. The search starts just after
    // the owner and excludes the owner. On a release, req[owner] is already
    // 0, so the mask does not change the result in that case.
    w_next_hit    = rr_search(w_others, w_after_owner);
    w_hold_expired = (MAX_HOLD != 0) && (r_cnt == c_max_hold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 8'h00;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The pointer does not move on the initial grant.
          if (w_idle_hit[3]) begin
            r_grant <= 8'(1) << w_idle_hit[2:0];
            r_sel   <= w_idle_hit[2:0];
            r_valid <= 1'b1;
            r_cnt   <= c_cnt_start;
            r_state <= S_OWN;
          end
        end

        S_OWN: begin
          if (!w_owner_req) begin
            // Release. The grant moves to the next requester on this same
            // edge, so there is no idle bubble between owners.
            r_ptr <= w_after_owner;
            if (w_next_hit[3]) begin
              r_grant <= 8'(1) << w_next_hit[2:0];
              r_sel   <= w_next_hit[2:0];
              r_cnt   <= c_cnt_start;
            end else begin
              // sel keeps the last owner so that the mux output stays stable.
              r_grant <= 8'h00;
              r_valid <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end else if (w_hold_expired && (|w_others)) begin
            // Preempt. The owner has used up its hold and someone is waiting.
            r_ptr   <= w_after_owner;
            r_grant <= 8'(1) << w_next_hit[2:0];
            r_sel   <= w_next_hit[2:0];
            r_cnt   <= c_cnt_start;
          end else if (MAX_HOLD == 0) begin
            r_cnt <= '0;
          end else if (r_cnt != c_max_hold) begin
            // The counter saturates at the limit, so a lone owner never wraps.
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_rr_arbiter
//  Description : Directed, self-checking bench for mux8_rr_arbiter. Three
//                instances share the clock and the reset:
//                  d=0 uses MAX_HOLD=4, d=1 uses MAX_HOLD=0, d=2 uses MAX_HOLD=1.
//                Each step drives one request vector and queues the expected
//                grant and sel. After the next rising edge the step pops the
//                queued entry and compares it with the instance outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] rq [3];
  logic [7:0] g  [3];
  logic [2:0] s  [3];
  logic       v  [3];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         d;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u_hold4 (
    .clk(clk), .rst_n(rst_n), .req(rq[0]), .grant(g[0]), .sel(s[0]), .valid(v[0]));
  mux8_rr_arbiter #(.MAX_HOLD(0), .CNT_W(3)) u_hold0 (
    .clk(clk), .rst_n(rst_n), .req(rq[1]), .grant(g[1]), .sel(s[1]), .valid(v[1]));
  mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(3)) u_hold1 (
    .clk(clk), .rst_n(rst_n), .req(rq[2]), .grant(g[2]), .sel(s[2]), .valid(v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int d, input logic [7:0] eg, input logic [2:0] es);
    exp_t e;
    e.d = d;
    e.g = eg;
    e.s = es;
    e.v = (eg != 8'h00);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    logic inv_ok;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed nothing, expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    assert (g[e.d] === e.g && s[e.d] === e.s && v[e.d] === e.v) else begin
      miscompares++;
      $error("FAIL %s: dut%0d observed grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
             tag, e.d, g[e.d], s[e.d], v[e.d], e.g, e.s, e.v);
    end
    // Structural invariants on the same instance: the grant is one-hot or
    // zero, valid equals |grant, and grant[sel] equals valid.
    inv_ok = $onehot0(g[e.d]) && (v[e.d] === (|g[e.d])) && (g[e.d][s[e.d]] === v[e.d]);
    vectors++;
    assert (inv_ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_inv: dut%0d observed grant=%h sel=%0d valid=%b, expected onehot0 grant with grant[sel]==valid==|grant",
             tag, e.d, g[e.d], s[e.d], v[e.d]);
    end
  endtask

  // Drive the request vector, queue the expected result, and check it after
  // the sampling edge.
  task automatic step(input int d, input logic [7:0] r, input logic [7:0] eg,
                      input logic [2:0] es, input string tag);
    rq[d] = r;
    push_exp(d, eg, es);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) rq[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_exp(i, 8'h00, 3'd0);
    for (int i = 0; i < 3; i++) pop_check("reset_state");
    #3 rst_n = 1'b1;

    // Assert reset while instance 0 holds a grant.
    step(0, 8'h04, 8'h04, 3'd2, "rst_pre_c1");
    step(0, 8'h04, 8'h04, 3'd2, "rst_pre_c2");
    step(0, 8'h04, 8'h04, 3'd2, "rst_pre_c3");
    #3 rst_n = 1'b0;
    #1;
    push_exp(0, 8'h00, 3'd0);
    pop_check("rst_async");
    #2 rst_n = 1'b1;
    step(0, 8'h04, 8'h04, 3'd2, "rst_regrant");

    // A single requester with MAX_HOLD=4 is never preempted.
    for (int c = 0; c < 10; c++) step(0, 8'h20, 8'h20, 3'd5, "single_hold");
    step(0, 8'h00, 8'h00, 3'd5, "single_drop");

    // Owner 3 releases with no contenders. The pointer becomes 4, so the scan
    // 4,5,6,7,0,1 finds bit 1 first.
    step(0, 8'h08, 8'h08, 3'd3, "own3_grant");
    step(0, 8'h08, 8'h08, 3'd3, "own3_hold");
    step(0, 8'h00, 8'h00, 3'd3, "own3_release");
    step(0, 8'h0A, 8'h02, 3'd1, "idle_ptr_search");
    step(0, 8'h00, 8'h00, 3'd1, "idle_again");

    // Preemption with MAX_HOLD=4: owner 2, then owner 6, then owner 2.
    step(0, 8'h04, 8'h04, 3'd2, "pre_c1");
    for (int c = 0; c < 3; c++) step(0, 8'h44, 8'h04, 3'd2, "pre_own2");
    for (int c = 0; c < 4; c++) step(0, 8'h44, 8'h40, 3'd6, "pre_own6");
    step(0, 8'h44, 8'h04, 3'd2, "pre_back2");
    step(0, 8'h00, 8'h00, 3'd2, "pre_idle");

    // Rotation with MAX_HOLD=0: the grant wraps 0 -> 7 -> 0 with no bubble.
    step(1, 8'h81, 8'h01, 3'd0, "rr_own0");
    step(1, 8'h81, 8'h01, 3'd0, "rr_own0_hold");
    step(1, 8'h80, 8'h80, 3'd7, "rr_to7");
    step(1, 8'h81, 8'h80, 3'd7, "rr_own7_hold");
    step(1, 8'h01, 8'h01, 3'd0, "rr_wrap0");
    step(1, 8'h81, 8'h01, 3'd0, "rr_own0_hold2");
    step(1, 8'h80, 8'h80, 3'd7, "rr_to7_again");

    // Fairness sweep with MAX_HOLD=1: sel steps through 0..7 and back to 0.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] eg;
      eg = 8'h01 << (k % 8);
      step(2, 8'hFF, eg, 3'(k % 8), "fair_sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
